// File: rtl/weight_pkg.sv
// Shared types and default sizing for the weight loading path into the UltraRAM weight store.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package weight_pkg;

  localparam int          IN_WIDTH          = 32;
  localparam int          WEIGHT_DATA_WIDTH = 64;
  localparam logic [31:0] WEIGHT_BASE_ADDR  = 32'h4000_0000;
  localparam int          KERNEL_NUM        = 1024;
  localparam int          BLOCK_RAM_NUM     = 8;

  typedef enum logic [1:0] {IDLE, LOAD} loader_state_t;

  typedef logic [$clog2(KERNEL_NUM):0] kcnt_t;

endpackage

// File: rtl/weight_loader_beat_packer.sv
// Packs narrow stream beats into one wide word, first beat in the lowest lane.
// Latency: word_valid/word are combinational on the beat that completes the word.
// Backpressure: none; every in_valid beat is taken, flush drops any partial word.
module beat_packer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             word_valid,
  output logic [OUT_W-1:0] word
);

  localparam int BEATS = OUT_W / IN_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] acc;
  logic             last_beat;

  assign last_beat = (cnt == CW'(BEATS - 1));

  // Beat counter and lane accumulator; a flush or reset restarts at lane 0.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '0;
      acc <= '0;
    end else if (in_valid) begin
      acc[cnt*IN_W +: IN_W] <= in_data;
      cnt <= last_beat ? '0 : cnt + CW'(1);
    end
  end

  // Present the completed word, merging the current beat into its lane.
  always_comb begin
    word                  = acc;
    word[cnt*IN_W +: IN_W] = in_data;
    word_valid            = in_valid && last_beat;
  end

endmodule

// File: rtl/weight_loader.sv
// Feeds the weight store: packs stream beats into words, one write per word, bank-rotated addressing.
// Latency: 1 cycle from the word-completing beat to wr_en.
// Backpressure: s_ready only while loading; the store never stalls, so there is no output stall path.
module weight_loader
  import weight_pkg::*;
#(
  parameter int          pIN_WIDTH          = IN_WIDTH,
  parameter int          pWEIGHT_DATA_WIDTH = WEIGHT_DATA_WIDTH,
  parameter logic [31:0] pWEIGHT_BASE_ADDR  = WEIGHT_BASE_ADDR,
  parameter int          pKERNEL_NUM        = KERNEL_NUM,
  parameter int          pBLOCK_RAM_NUM     = BLOCK_RAM_NUM
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(pKERNEL_NUM):0]  kernel_cnt,
  input  logic [pIN_WIDTH-1:0]          s_data,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic                          wr_en,
  output logic [31:0]                   weight_addr,
  output logic [pWEIGHT_DATA_WIDTH-1:0] weight_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int KW = $clog2(pKERNEL_NUM) + 1;
  localparam int BW = (pBLOCK_RAM_NUM > 1) ? $clog2(pBLOCK_RAM_NUM) : 1;

  loader_state_t state, next_state;

  logic [KW-1:0] kcnt_q;
  logic [KW-1:0] kidx;
  logic [BW-1:0] bank;

  logic                          accept;
  logic                          start_ok;
  logic                          word_valid;
  logic [pWEIGHT_DATA_WIDTH-1:0] word;
  logic                          final_word;
  logic                          bad_last;
  logic                          do_write;
  logic                          finish;

  assign s_ready  = (state == LOAD);
  assign busy     = (state == LOAD);
  assign accept   = s_valid && s_ready;
  assign start_ok = (state == IDLE) && start;

  // The final word of a load is the last bank of the last requested kernel.
  assign final_word = (kidx == kcnt_q - KW'(1)) && (bank == BW'(pBLOCK_RAM_NUM - 1));
  // s_last is only legal on the beat that completes the final word.
  assign bad_last   = accept && s_last && !(word_valid && final_word);
  assign do_write   = word_valid && !bad_last;
  assign finish     = do_write && final_word;

  beat_packer #(
    .IN_W  (pIN_WIDTH),
    .OUT_W (pWEIGHT_DATA_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .flush      (bad_last || start_ok),
    .in_valid   (accept),
    .in_data    (s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: load on a non-zero start, leave on the final write or a misplaced s_last.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start && kernel_cnt != '0) next_state = LOAD;
      LOAD: if (finish || bad_last)        next_state = IDLE;
      default:                             next_state = IDLE;
    endcase
  end

  // Write port, bank/kernel counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en       <= 1'b0;
      weight_addr <= '0;
      weight_data <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      kcnt_q      <= '0;
      kidx        <= '0;
      bank        <= '0;
    end else begin
      wr_en <= do_write;
      done  <= finish || (start_ok && kernel_cnt == '0);
      if (do_write) begin
        weight_data <= word;
        weight_addr <= pWEIGHT_BASE_ADDR + 32'(kidx);
      end
      if (start_ok) begin
        kcnt_q <= kernel_cnt;
        kidx   <= '0;
        bank   <= '0;
        err    <= 1'b0;
      end else begin
        if (do_write) begin
          if (bank == BW'(pBLOCK_RAM_NUM - 1)) begin
            bank <= '0;
            kidx <= kidx + KW'(1);
          end else begin
            bank <= bank + BW'(1);
          end
        end
        if (bad_last) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader with a write scoreboard.
// Latency: expects wr_en one cycle after each word-completing beat.
// Backpressure: beats are only presented while s_ready is observed high.
module tb_weight_loader;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] kernel_cnt = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        wr_en;
  logic [31:0] weight_addr;
  logic [63:0] weight_data;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    bit          last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_count = 0;
  int   done_count = 0;
  bit   zd_exp = 0;

  always #5 clk = ~clk;

  weight_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .kernel_cnt  (kernel_cnt),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .wr_en       (wr_en),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_count++;
      if (wr_en) begin
        wr_count++;
        if (q.size() == 0) begin
          chk("unexpected_wr", 64'(weight_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wr_addr", 64'(weight_addr), 64'(e.addr));
          chk("wr_data", weight_data, e.data);
          chk("done_at_wr", 64'(done), 64'(e.last));
        end
      end else if (done) begin
        chk("done_no_wr", 64'(zd_exp), 64'd1);
        zd_exp = 0;
      end
    end
  end

  task automatic start_load(input int kc);
    @(negedge clk);
    start = 1'b1;
    kernel_cnt = 11'(kc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic l, output bit ok);
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        break;
      end
      s_valid = 1'b0;
    end
    s_valid = ok;
    s_data  = d;
    s_last  = l;
  endtask

  // Drive nbeats beats valued 1..nbeats; s_last on beat last_at (0: never).
  task automatic run_load(input int kc, input int nbeats, input int last_at,
                          input int gap, input int mid_start_at);
    logic [31:0] prev;
    bit          ok;
    bit          erroneous;
    exp_t        e;
    prev = '0;
    erroneous = (last_at > 0) && (last_at != kc * 16);
    start_load(kc);
    for (int i = 1; i <= nbeats; i++) begin
      if (gap > 0 && i > 1) begin
        @(negedge clk);
        s_valid = 1'b0;
        start = 1'b0;
      end
      drive_beat(32'(i), (i == last_at), ok);
      start = (i == mid_start_at);
      kernel_cnt = start ? 11'd5 : 11'(kc);
      if (!ok) begin
        chk("beat_timeout", 64'd0, 64'd1);
        break;
      end
      if (i % 2 == 0) begin
        if (!(erroneous && i >= last_at)) begin
          e.addr = BASE + 32'((i / 2 - 1) / 8);
          e.data = {32'(i), prev};
          e.last = (i == kc * 16);
          q.push_back(e);
        end
      end else begin
        prev = 32'(i);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 40 && q.size() > 0; c++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_addr", 64'(weight_addr), 64'd0);
    chk("rst_data", weight_data, 64'd0);
    rst = 1'b0;

    // 1: single kernel, contiguous beats.
    d0 = done_count;
    run_load(1, 16, 16, 0, 0);
    @(negedge clk);
    chk("t1_done_count", 64'(done_count - d0), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);

    // 2: three kernels with s_valid toggling.
    d0 = done_count;
    w0 = wr_count;
    run_load(3, 48, 48, 1, 0);
    @(negedge clk);
    chk("t2_writes", 64'(wr_count - w0), 64'd24);
    chk("t2_done_count", 64'(done_count - d0), 64'd1);

    // 3: misplaced s_last, then recovery.
    d0 = done_count;
    w0 = wr_count;
    run_load(2, 5, 5, 0, 0);
    repeat (3) @(negedge clk);
    chk("t3_err", 64'(err), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    chk("t3_writes", 64'(wr_count - w0), 64'd2);
    chk("t3_no_done", 64'(done_count - d0), 64'd0);
    run_load(1, 16, 16, 0, 0);
    chk("t3_err_cleared", 64'(err), 64'd0);

    // 4: reset after three writes of a two-kernel load.
    w0 = wr_count;
    run_load(2, 6, 0, 0, 0);
    chk("t4_writes", 64'(wr_count - w0), 64'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_wr_en", 64'(wr_en), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_addr", 64'(weight_addr), 64'd0);
    chk("t4_data", weight_data, 64'd0);
    rst = 1'b0;
    run_load(1, 16, 16, 0, 0);

    // 5: start during LOAD ignored, then zero-count start.
    d0 = done_count;
    run_load(2, 32, 32, 0, 7);
    @(negedge clk);
    chk("t5_done_count", 64'(done_count - d0), 64'd1);
    zd_exp = 1;
    start = 1'b1;
    kernel_cnt = '0;
    @(negedge clk);
    start = 1'b0;
    chk("t5_zero_done", 64'(done), 64'd1);
    chk("t5_zero_wr", 64'(wr_en), 64'd0);
    chk("t5_zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t5_zero_done_once", 64'(done), 64'd0);
    chk("t5_zero_consumed", 64'(zd_exp), 64'd0);

    // 6: full-size load.
    w0 = wr_count;
    d0 = done_count;
    run_load(1024, 16384, 16384, 0, 0);
    @(negedge clk);
    chk("t6_writes", 64'(wr_count - w0), 64'd8192);
    chk("t6_done_count", 64'(done_count - d0), 64'd1);
    chk("t6_last_addr", 64'(weight_addr), 64'(BASE + 32'd1023));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
